// File: rtl/sr_write_arbiter.sv
// rtl/sr_write_arbiter.sv - round-robin arbiter sharing one serial shift-register write engine
module sr_write_arbiter #(
    parameter int DATA_WIDTH = 170,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int TO_WIDTH   = 10,
    parameter int TIMEOUT    = 400
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [DATA_WIDTH-1:0]         eng_din,
    output logic                          eng_start,
    input  logic                          eng_load_sr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_REC1,
        S_REC2,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic [NUM_REQ-1:0]    err_q, err_d;
    logic                  busy_q, busy_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic [ID_WIDTH-1:0]   last_q, last_d;
    logic [DATA_WIDTH-1:0] eng_din_q, eng_din_d;
    logic                  eng_start_q, eng_start_d;
    logic [TO_WIDTH-1:0]   timer_q, timer_d;
    logic                  to_q, to_d;

    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic [DATA_WIDTH-1:0] win_data;

    // Scan last+1, last+2, ... modulo NUM_REQ; the first set request wins.
    always_comb begin : rr_pick
        int idx;
        found    = 1'b0;
        winner   = '0;
        win_data = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req[i]) begin
                    found    = 1'b1;
                    winner   = ID_WIDTH'(i);
                    win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        err_d       = '0;
        busy_d      = busy_q;
        grant_id_d  = grant_id_q;
        last_d      = last_q;
        eng_din_d   = eng_din_q;
        eng_start_d = 1'b0;
        timer_d     = timer_q;
        to_d        = to_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    eng_din_d  = win_data;
                    grant_id_d = winner;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                timer_d     = '0;
                eng_start_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 1'b1;
                // A load strobe on the final timer cycle still counts as success.
                if (eng_load_sr) begin
                    to_d    = 1'b0;
                    state_d = S_REC1;
                end else if (timer_q == TO_WIDTH'(TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_REC1;
                end
            end
            S_REC1: state_d = S_REC2;
            S_REC2: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (grant_id_q == ID_WIDTH'(i)) begin
                        ack_d[i] = 1'b1;
                        err_d[i] = to_q;
                    end
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                last_d  = grant_id_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ack_q       <= '0;
            err_q       <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            last_q      <= ID_WIDTH'(NUM_REQ - 1);
            eng_din_q   <= '0;
            eng_start_q <= 1'b0;
            timer_q     <= '0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            last_q      <= last_d;
            eng_din_q   <= eng_din_d;
            eng_start_q <= eng_start_d;
            timer_q     <= timer_d;
            to_q        <= to_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
    assign eng_din   = eng_din_q;
    assign eng_start = eng_start_q;

endmodule

// File: doc/sr_write_arbiter.md
Name: sr_write_arbiter

Overview:
Shares one serial shift-register write engine among NUM_REQ requesters, for example per-chip configuration sources and the host register path. The block arbitrates round-robin and latches the winner's DATA_WIDTH-bit word. It pulses the engine's start, waits for the engine's load strobe, then returns a per-requester ack with a timeout error flag. It sits directly in front of the write engine: its eng_din, eng_start and eng_load_sr connect to the engine's din, start and load_sr.

Parameters:
DATA_WIDTH, 170, width of one shift-register configuration word.
NUM_REQ, 4, number of requesters (2..8).
ID_WIDTH, 2, width of grant_id; 2**ID_WIDTH >= NUM_REQ.
TO_WIDTH, 10, width of the watchdog counter.
TIMEOUT, 400, WAIT cycles before abort. Must be > DATA_WIDTH+4 and < 2**TO_WIDTH.

Ports:
clk  in  1  control clock; everything is on its rising edge.
rst  in  1  reset; asynchronous, active-low (0 = reset).
req  in  NUM_REQ  per-requester write request; level, held until ack.
req_data  in  NUM_REQ*DATA_WIDTH  requester i's word is at bits [i*DATA_WIDTH +: DATA_WIDTH].
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
err  out  NUM_REQ  one-cycle pulse, coincident with ack; 1 = engine timed out.
busy  out  1  high in every state except IDLE.
grant_id  out  ID_WIDTH  index of the current or last-granted requester.
eng_din  out  DATA_WIDTH  latched word to the engine; stable from START through DONE.
eng_start  out  1  one-cycle start pulse to the engine.
eng_load_sr  in  1  engine load strobe; marks the end of the shift.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - ack, err, eng_start, busy = 0; eng_din = 0; grant_id = 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority after reset.
  - Timer = 0; timeout flag = 0.
- All outputs are registered. No combinational path from req or eng_load_sr to any output.
- States are IDLE, START, WAIT, REC1, REC2, DONE.
- IDLE:
  - If any req bit is 1, select the first set bit scanning last+1, last+2, ... modulo NUM_REQ.
  - At that edge: latch eng_din = the winner's req_data slice, grant_id = winner, busy = 1, go to START.
  - If req == 0, stay in IDLE.
- START:
  - eng_start = 1 for exactly this cycle. Timer cleared. Go to WAIT.
  - Latency: req first sampled high in cycle R (while IDLE) gives eng_start high in cycle R+2.
- WAIT:
  - Timer increments each cycle.
  - If eng_load_sr = 1, go to REC1 with the timeout flag = 0.
  - Else if timer == TIMEOUT-1, go to REC1 with the timeout flag = 1.
  - If eng_load_sr arrives in the same cycle the timeout would fire, the load strobe wins: flag = 0.
- REC1, REC2:
  - Idle drain cycles that let the engine return to its idle state.
  - eng_start stays 0. eng_din is held.
- DONE:
  - ack[grant_id] = 1 and err[grant_id] = timeout flag, for this cycle only.
  - Update last = grant_id. Next state is IDLE.
  - eng_load_sr sampled high in WAIT cycle L gives ack high in cycle L+3.
- Back-to-back and fairness:
  - A requester still holding req after its ack is eligible again in the next IDLE cycle.
  - Round-robin order guarantees every other pending requester is served first.
  - With all requesters asserted continuously, the grant order is 0,1,2,3,0,...
- Requester behaviour:
  - req dropped mid-transaction does not abort it; ack/err are still pulsed and may be ignored.
  - req_data changes after the grant edge are ignored.
- eng_load_sr outside WAIT is ignored; no state change and no error.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - No ack is issued; the requester must re-request.
  - eng_start is never glitched high by reset.
- Widths:
  - Timer is TO_WIDTH bits and never wraps, because TIMEOUT < 2**TO_WIDTH.
  - Indices are computed modulo NUM_REQ; unused grant_id codes never occur.

Test Plan:
1. Reset release, then req=4'b0100 with data 170'h2AA...A: eng_start pulses once 2 cycles later with eng_din = that word; engine model raises eng_load_sr 174 cycles after start; ack=4'b0100 3 cycles after load, err=0, busy low the cycle after ack.
2. req=4'b1111 held for 8 transactions: grant_id sequence 0,1,2,3,0,1,2,3; exactly one ack per transaction, never two bits set.
3. Engine stalled (eng_load_sr held 0), TIMEOUT=400: ack and err both pulse for the granted requester exactly 400+3 cycles after START; the next request then proceeds normally.
4. eng_load_sr asserted on the timer==TIMEOUT-1 cycle: err=0.
5. rst pulsed low during WAIT: outputs 0 immediately, no ack; after release, req 0 is granted first and completes normally.
6. req dropped one cycle after grant and req_data changed during WAIT: eng_din unchanged; ack still pulses 3 cycles after load.
